// File: rtl/int_ctrl_prio_enc4.sv
// 4-bit fixed-priority encoder: the lowest set index wins (line 1 is highest priority).
module prio_enc4 (
   input  logic [3:0] req_i,
   output logic       valid_o,
   output logic [1:0] idx_o
);

   // Combinational priority scan from bit 0 upward.
   always_comb begin
      valid_o = 1'b1;
      idx_o   = 2'd0;
      if (req_i[0]) begin
         idx_o = 2'd0;
      end else if (req_i[1]) begin
         idx_o = 2'd1;
      end else if (req_i[2]) begin
         idx_o = 2'd2;
      end else if (req_i[3]) begin
         idx_o = 2'd3;
      end else begin
         valid_o = 1'b0;
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Four-line interrupt controller: edge-detected pending latches, mask/gie gating,
// fixed-priority acceptance, and a one-cycle acknowledge followed by service until reti.
module int_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq,
   input  logic       cfg_we,
   input  logic [4:0] cfg_in,
   input  logic       reti,
   output logic       ie1,
   output logic       ie2,
   output logic       ie3,
   output logic       ie4,
   output logic       in_service,
   output logic [1:0] active_id,
   output logic [3:0] pending,
   output logic [4:0] cfg_out
);

   localparam int unsigned NIRQ = 4;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StAck     = 2'd1;
   localparam logic [1:0] StService = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [NIRQ-1:0] irq_q;
   logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
   logic            hist_vld_q;
   logic [NIRQ-1:0] pend_q, pend_d;
   logic [NIRQ-1:0] pend_set, pend_clr;
   logic [4:0]      cfg_q, cfg_d;
   logic [NIRQ-1:0] ie_q, ie_d;
   logic [1:0]      id_q, id_d;

   logic            gie;
   logic [NIRQ-1:0] mask;
   logic [NIRQ-1:0] eligible;
   logic            win_vld;
   logic [1:0]      win_idx;

   assign gie      = cfg_q[4];
   assign mask     = cfg_q[3:0];
   assign eligible = pend_q & mask;

   prio_enc4 u_prio (
      .req_i   (eligible),
      .valid_o (win_vld),
      .idx_o   (win_idx)
   );

   // On the first clocked sample after reset both history stages load the live irq,
   // so a line already high at reset release never looks like a rising edge.
   assign irq_prev_d = hist_vld_q ? irq_q : irq;
   assign pend_set   = irq_q & ~irq_prev_q;

   // irq sampling history, two stages deep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q      <= '0;
         irq_prev_q <= '0;
         hist_vld_q <= 1'b0;
      end else begin
         irq_q      <= irq;
         irq_prev_q <= irq_prev_d;
         hist_vld_q <= 1'b1;
      end
   end

   // Next-state: acceptance, acknowledge pulse, service and return.
   always_comb begin
      state_d  = state_q;
      ie_d     = '0;
      id_d     = id_q;
      pend_clr = '0;
      case (state_q)
         StIdle: begin
            if (gie && win_vld) begin
               state_d  = StAck;
               id_d     = win_idx;
               ie_d     = NIRQ'(1) << win_idx;
               pend_clr = NIRQ'(1) << win_idx;
            end
         end
         StAck: begin
            state_d = StService;
         end
         StService: begin
            if (reti) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // A new edge arriving on the bit being accepted keeps it pending.
   assign pend_d = (pend_q & ~pend_clr) | pend_set;
   assign cfg_d  = cfg_we ? cfg_in : cfg_q;

   // Controller state registers; ie pulses come straight from flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pend_q  <= '0;
         cfg_q   <= '0;
         ie_q    <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cfg_q   <= cfg_d;
         ie_q    <= ie_d;
         id_q    <= id_d;
      end
   end

   assign ie1        = ie_q[0];
   assign ie2        = ie_q[1];
   assign ie3        = ie_q[2];
   assign ie4        = ie_q[3];
   assign in_service = (state_q == StService);
   assign active_id  = id_q;
   assign pending    = pend_q;
   assign cfg_out    = cfg_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: expected acknowledge pulses are queued with their cycle when
// stimulus is driven and compared by a negedge monitor; state is spot-checked inline.
module tb_int_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] irq;
   logic       cfg_we;
   logic [4:0] cfg_in;
   logic       reti;
   logic       ie1, ie2, ie3, ie4;
   logic       in_service;
   logic [1:0] active_id;
   logic [3:0] pending;
   logic [4:0] cfg_out;
   logic [3:0] ie_v;

   typedef struct {
      int cyc;
      int id;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errs = 0;

   int_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .cfg_we     (cfg_we),
      .cfg_in     (cfg_in),
      .reti       (reti),
      .ie1        (ie1),
      .ie2        (ie2),
      .ie3        (ie3),
      .ie4        (ie4),
      .in_service (in_service),
      .active_id  (active_id),
      .pending    (pending),
      .cfg_out    (cfg_out)
   );

   assign ie_v = {ie4, ie3, ie2, ie1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Acknowledge monitor: exactly the queued one-hot in its cycle, nothing otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         check_eq("ie_vec", {28'd0, ie_v}, 32'd1 << e.id);
         check_eq("ack_id", {30'd0, active_id}, e.id);
      end else begin
         check_eq("ie_quiet", {28'd0, ie_v}, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_ie(input int at, input int id);
      exp_t e;
      e.cyc = at;
      e.id  = id;
      q.push_back(e);
   endtask

   task automatic write_cfg(input logic [4:0] v);
      cfg_in = v;
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_irq(input logic [3:0] b);
      irq = irq | b;
      tick();
      irq = irq & ~b;
   endtask

   task automatic do_reti();
      reti = 1'b1;
      tick();
      reti = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      irq    = '0;
      cfg_we = 1'b0;
      cfg_in = '0;
      reti   = 1'b0;
      ticks(2);
      check_eq("rst_pend", {28'd0, pending}, 32'h0);
      check_eq("rst_cfg", {27'd0, cfg_out}, 32'h0);
      check_eq("rst_svc", {31'd0, in_service}, 32'h0);
      check_eq("rst_id", {30'd0, active_id}, 32'h0);
      reset = 1'b0;
      ticks(2);

      // Single line, latency 3 edges after the rise.
      write_cfg(5'b1_0001);
      check_eq("cfg_load", {27'd0, cfg_out}, 32'h11);
      push_ie(cyc + 3, 0);
      pulse_irq(4'b0001);
      tick();
      check_eq("pend_set", {28'd0, pending}, 32'h1);
      ticks(2);
      check_eq("svc_on", {31'd0, in_service}, 32'h1);
      check_eq("pend_clr", {28'd0, pending}, 32'h0);
      ticks(3);
      check_eq("svc_hold", {31'd0, in_service}, 32'h1);
      do_reti();
      check_eq("svc_off", {31'd0, in_service}, 32'h0);
      check_eq("id_hold", {30'd0, active_id}, 32'h0);

      // Two simultaneous lines: line 2 first, then line 4 after reti.
      write_cfg(5'b1_1111);
      push_ie(cyc + 3, 1);
      pulse_irq(4'b1010);
      ticks(3);
      check_eq("prio_id", {30'd0, active_id}, 32'h1);
      check_eq("prio_pend", {28'd0, pending}, 32'h8);
      ticks(2);
      push_ie(cyc + 2, 3);
      do_reti();
      ticks(3);
      check_eq("b2b_id", {30'd0, active_id}, 32'h3);
      check_eq("b2b_svc", {31'd0, in_service}, 32'h1);
      do_reti();
      check_eq("b2b_pend", {28'd0, pending}, 32'h0);

      // Masked line stays pending, fires once unmasked.
      write_cfg(5'b1_0000);
      pulse_irq(4'b0100);
      ticks(4);
      check_eq("mask_pend", {28'd0, pending}, 32'h4);
      check_eq("mask_svc", {31'd0, in_service}, 32'h0);
      push_ie(cyc + 2, 2);
      write_cfg(5'b1_0100);
      ticks(3);
      check_eq("unmask_id", {30'd0, active_id}, 32'h2);
      check_eq("unmask_pend", {28'd0, pending}, 32'h0);
      do_reti();

      // Same line again during service: no nesting, re-fires after reti.
      write_cfg(5'b1_1111);
      push_ie(cyc + 3, 0);
      pulse_irq(4'b0001);
      ticks(3);
      pulse_irq(4'b0001);
      ticks(2);
      check_eq("nest_pend", {28'd0, pending}, 32'h1);
      check_eq("nest_svc", {31'd0, in_service}, 32'h1);
      push_ie(cyc + 2, 0);
      do_reti();
      ticks(3);
      check_eq("refire_pend", {28'd0, pending}, 32'h0);
      do_reti();

      // New edge on the bit being accepted: set wins.
      write_cfg(5'b0_1111);
      pulse_irq(4'b0001);
      ticks(3);
      check_eq("gie0_pend", {28'd0, pending}, 32'h1);
      cfg_in = 5'b1_1111;
      cfg_we = 1'b1;
      irq    = 4'b0001;
      push_ie(cyc + 2, 0);
      tick();
      cfg_we = 1'b0;
      irq    = 4'b0000;
      ticks(3);
      check_eq("set_wins", {28'd0, pending}, 32'h1);
      push_ie(cyc + 2, 0);
      do_reti();
      ticks(3);
      check_eq("set_wins_clr", {28'd0, pending}, 32'h0);
      do_reti();

      // reti in idle ignored; clearing gie in service does not end it.
      do_reti();
      check_eq("reti_idle", {31'd0, in_service}, 32'h0);
      push_ie(cyc + 3, 1);
      pulse_irq(4'b0010);
      ticks(3);
      write_cfg(5'b0_1111);
      ticks(2);
      check_eq("gie0_cfg", {27'd0, cfg_out}, 32'h0f);
      check_eq("gie0_svc", {31'd0, in_service}, 32'h1);
      do_reti();
      check_eq("gie0_ret", {31'd0, in_service}, 32'h0);

      // Config write in the ACK cycle does not cancel the acknowledge.
      write_cfg(5'b1_1111);
      push_ie(cyc + 3, 2);
      pulse_irq(4'b0100);
      ticks(2);
      write_cfg(5'b0_0000);
      tick();
      check_eq("ack_cfg_svc", {31'd0, in_service}, 32'h1);
      check_eq("ack_cfg_id", {30'd0, active_id}, 32'h2);
      do_reti();

      // Reset during ACK aborts at once; irq held high across release is ignored.
      write_cfg(5'b1_1111);
      push_ie(cyc + 3, 0);
      pulse_irq(4'b0001);
      ticks(2);
      @(negedge clk);
      #1;
      reset = 1'b1;
      irq   = 4'b0001;
      #1;
      check_eq("rst_ack_ie", {28'd0, ie_v}, 32'h0);
      check_eq("rst_ack_cfg", {27'd0, cfg_out}, 32'h0);
      check_eq("rst_ack_pend", {28'd0, pending}, 32'h0);
      check_eq("rst_ack_id", {30'd0, active_id}, 32'h0);
      ticks(2);
      reset = 1'b0;
      ticks(6);
      check_eq("rst_hi_pend", {28'd0, pending}, 32'h0);
      write_cfg(5'b1_1111);
      ticks(4);
      check_eq("rst_hi_svc", {31'd0, in_service}, 32'h0);
      irq = 4'b0000;
      ticks(3);

      check_eq("sb_drain", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NIRQ, default 4, number of interrupt lines (fixed at 4 for this CPU).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 irq  input  4  peripheral/timer interrupt requests, level in, rising edge significant; bit 0 = line 1.
REQ-005 cfg_we  input  1  one-cycle strobe from control unit: load configuration register.
REQ-006 cfg_in  input  5  {gie, mask[3:0]}; mask bit i = 1 enables line i.
REQ-007 reti  input  1  one-cycle strobe from control unit: return-from-interrupt decoded.
REQ-008 ie1, ie2, ie3, ie4  output  1 each  one-hot request to datapath (PC vector select and stack push).
REQ-009 in_service  output  1  high while a handler is executing.
REQ-010 active_id  output  2  index of the line being serviced (0..3).
REQ-011 pending  output  4  current pending-latch contents.
REQ-012 cfg_out  output  5  current {gie, mask}.

Function
REQ-013 Edge detect: irq registered each cycle; pending[i] SHALL set on the edge after irq[i] is sampled 1 having been sampled 0 the previous cycle.
REQ-014 Pending bits SHALL be latched regardless of mask or gie; masking only gates acceptance.
REQ-015 Eligible set = pending & mask, qualified by gie = 1 and state IDLE.
REQ-016 Fixed priority: lowest index wins (line 1 highest).
REQ-017 FSM states IDLE, ACK, SERVICE.
REQ-018 IDLE -> ACK on the edge where the eligible set is non-empty; same edge registers active_id, sets the winning ie output, clears that pending bit.
REQ-019 ACK lasts exactly one cycle: exactly one ieN high, all others low; ACK -> SERVICE unconditionally.
REQ-020 ieN SHALL never be high outside ACK; never more than one high.
REQ-021 SERVICE: in_service = 1; no nesting; further edges only set pending bits.
REQ-022 SERVICE -> IDLE on the edge reti is sampled 1; reti in IDLE or ACK SHALL be ignored.
REQ-023 Latency: irq rising sampled at edge k -> pending at k+1 -> ieN high during cycle after edge k+2 (if eligible and IDLE).
REQ-024 Simultaneous new edge and acceptance clear on same bit: set wins (bit stays pending).
REQ-025 cfg_we takes effect at the next edge; a write during ACK does not cancel that acknowledge; clearing gie in SERVICE does not end service.
REQ-026 Back-to-back: after reti, a still-eligible pending bit SHALL be accepted at the edge after returning to IDLE (one idle cycle minimum).
REQ-027 in_service, active_id hold their value throughout SERVICE; active_id holds its last value in IDLE.

Reset
REQ-028 On reset: state IDLE, pending = 0, irq history = 0, gie = 0, mask = 0, ie1..ie4 = 0, in_service = 0, active_id = 0.
REQ-029 Reset asserted mid-ACK or mid-SERVICE SHALL abort immediately (asynchronous) with no residual ie pulse.
REQ-030 irq held high through reset deassertion SHALL NOT create a pending bit (history reset to 0 counts as edge only if irq rises after the first clocked sample).

Structure
REQ-031 FSM state encoding and NIRQ SHALL be localparams in the module; no shared package (codebase is plain Verilog).
REQ-032 One sub-module is natural: prio_enc4 (4-bit fixed-priority encoder, valid + 2-bit index), combinational.
REQ-033 ie1..ie4 SHALL be driven from flops, not from combinational decode.

Verification
REQ-034 Reset, cfg_in = 5'b1_0001, irq[0] pulse -> ie1 high exactly one cycle 3 edges after rise, active_id = 0, in_service = 1 until reti.
REQ-035 irq = 4'b1010 same cycle, mask = 4'b1111, gie = 1 -> ie2 first; after reti, ie4 next; pending returns to 0.
REQ-036 mask = 4'b0000, irq[2] pulse -> no ie; pending = 4'b0100; then cfg_in = 5'b1_0100 -> ie3 pulse.
REQ-037 In SERVICE of line 1, irq[0] edge again -> pending[0] = 1, no ie; reti -> ie1 re-fires after one idle cycle.
REQ-038 Reset asserted during ACK -> ie outputs drop same cycle, all state 0; irq held high across reset release -> no interrupt.
REQ-039 reti strobed in IDLE -> no state change; cfg_we gie = 0 during SERVICE -> service continues to reti.
